// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings and alignment check for the data memory stage
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

    // The reserved size code behaves as a word, so it shares the word alignment rule.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SIZE_BYTE: is_misaligned = 1'b0;
            SIZE_HALF: is_misaligned = lo[0];
            default:   is_misaligned = (lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/data_mem_unit_if.sv
// rtl/data_mem_unit_if.sv - request/response bus between pipeline and data memory stage
interface data_mem_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  size;
    logic        load_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic [31:0] rdata;
    logic        misalign;

    modport master (
        output req_valid, mem_read, mem_write, size, load_unsigned, addr, wdata,
        input  req_ready, rsp_valid, rdata, misalign
    );

    modport slave (
        input  req_valid, mem_read, mem_write, size, load_unsigned, addr, wdata,
        output req_ready, rsp_valid, rdata, misalign
    );
endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - little-endian store merge and load extract/extend
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lo,
    input  logic        load_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [31:0] wword,
    output logic [31:0] rfmt
);

    logic [3:0]  be;
    logic [31:0] wlane;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        be    = 4'b0000;
        wlane = 32'h0;
        case (size)
            SIZE_BYTE: begin
                be    = 4'b0001 << lo;
                wlane = {4{wdata[7:0]}};
            end
            SIZE_HALF: begin
                be    = lo[1] ? 4'b1100 : 4'b0011;
                wlane = {2{wdata[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = wdata;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            wword[8*i +: 8] = be[i] ? wlane[8*i +: 8] : rword[8*i +: 8];
        end
    end

    always_comb begin
        byte_sel = rword[{lo, 3'b000} +: 8];
        half_sel = lo[1] ? rword[31:16] : rword[15:0];
        case (size)
            SIZE_BYTE: rfmt = {{24{~load_unsigned & byte_sel[7]}}, byte_sel};
            SIZE_HALF: rfmt = {{16{~load_unsigned & half_sel[15]}}, half_sel};
            default:   rfmt = rword;
        endcase
    end

endmodule

// File: rtl/data_mem_unit.sv
// rtl/data_mem_unit.sv - fixed-latency load/store memory stage with misalignment suppression
module data_mem_unit
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    data_mem_unit_if.slave  bus
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            accept, commit;

    logic [AW-1:0]   q_idx;
    logic [1:0]      q_lo, q_size;
    logic            q_lu, q_rd, q_wr;
    logic [31:0]     q_wdata;

    logic [AW-1:0]   cur_idx;
    logic [1:0]      cur_lo, cur_size;
    logic            cur_lu, cur_rd, cur_wr, cur_mis;
    logic [31:0]     cur_wdata;

    logic [31:0]     ram [DEPTH_WORDS];
    logic [31:0]     rword, wword, rfmt;
    logic [31:0]     rdata_q;
    logic            misalign_q;
    logic            unused_addr;

    assign accept        = bus.req_valid && (state == IDLE);
    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rdata     = rdata_q;
    assign bus.misalign  = misalign_q;
    assign unused_addr   = ^{bus.addr[31:AW+2]};

    // With LATENCY==1 the commit happens on the accept edge, so use the live request there.
    always_comb begin
        if (state == IDLE) begin
            cur_idx   = bus.addr[2 +: AW];
            cur_lo    = bus.addr[1:0];
            cur_size  = bus.size;
            cur_lu    = bus.load_unsigned;
            cur_rd    = bus.mem_read;
            cur_wr    = bus.mem_write;
            cur_wdata = bus.wdata;
        end else begin
            cur_idx   = q_idx;
            cur_lo    = q_lo;
            cur_size  = q_size;
            cur_lu    = q_lu;
            cur_rd    = q_rd;
            cur_wr    = q_wr;
            cur_wdata = q_wdata;
        end
        cur_mis = (cur_rd || cur_wr) && is_misaligned(cur_size, cur_lo);
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        commit  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_n = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_n = WAIT;
                        cnt_n   = CW'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_n = RESP;
                    commit  = 1'b1;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            q_idx      <= '0;
            q_lo       <= '0;
            q_size     <= '0;
            q_lu       <= 1'b0;
            q_rd       <= 1'b0;
            q_wr       <= 1'b0;
            q_wdata    <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                q_idx   <= bus.addr[2 +: AW];
                q_lo    <= bus.addr[1:0];
                q_size  <= bus.size;
                q_lu    <= bus.load_unsigned;
                q_rd    <= bus.mem_read;
                q_wr    <= bus.mem_write;
                q_wdata <= bus.wdata;
            end
            if (commit) begin
                rdata_q    <= (cur_rd && !cur_mis) ? rfmt : 32'h0;
                misalign_q <= cur_mis;
            end
        end
    end

    // RAM contents survive reset; the read above sees the pre-store word on the commit edge.
    always_ff @(posedge clk) begin
        if (commit && cur_wr && !cur_mis) begin
            ram[cur_idx] <= wword;
        end
    end

    assign rword = ram[cur_idx];

    mem_lane_align u_align (
        .size          (cur_size),
        .lo            (cur_lo),
        .load_unsigned (cur_lu),
        .wdata         (cur_wdata),
        .rword         (rword),
        .wword         (wword),
        .rfmt          (rfmt)
    );

endmodule
